// File: rtl/decode_stage.sv
// IF/ID pipeline register and instruction decoder for the 64-bit RISC-V core.
// Produces register-file read addresses, control signals, the immediate, and load-use stalls.
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            stall,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_imm,
  output logic            id_valid,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_branch,
  output logic            id_alu_src,
  output logic            id_mem_to_reg,
  output logic [1:0]      id_alu_op,
  output logic            id_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_CMP  = 2'b01;
  localparam logic [1:0] ALU_R    = 2'b10;
  localparam logic [1:0] ALU_IMM  = 2'b11;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } instr_class_e;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= if_valid;
      pc_q    <= if_pc;
      instr_q <= if_instr;
    end
  end

  logic [6:0] f_opcode;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [4:0] f_rd;

  assign f_opcode = instr_q[6:0];
  assign f_rs1    = instr_q[19:15];
  assign f_rs2    = instr_q[24:20];
  assign f_rd     = instr_q[11:7];

  // funct3 is not needed by this decoder; downstream ALU control reads it elsewhere.
  logic unused_funct3;
  assign unused_funct3 = ^instr_q[14:12];

  instr_class_e cls;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cls = CLS_ILLEGAL;
    unique case (f_opcode)
      OP_R:      cls = CLS_R;
      OP_I_ALU:  cls = CLS_I_ALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_sb;

  assign imm_i  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_sb = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                   instr_q[30:25], instr_q[11:8], 1'b0};

  logic uses_rs1;
  logic uses_rs2;
  logic hazard;

  assign uses_rs1 = valid_q && (cls != CLS_ILLEGAL);
  assign uses_rs2 = valid_q && (cls inside {CLS_R, CLS_STORE, CLS_BRANCH});

  // Writes to x0 are discarded, so a load targeting x0 can never create a dependency.
  assign hazard = valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (f_rs1 == ex_rd)) || (uses_rs2 && (f_rs2 == ex_rd)));

  assign stall = hazard && !flush;

  always_comb begin
    rs1           = '0;
    rs2           = '0;
    id_rd         = '0;
    id_pc         = '0;
    id_imm        = '0;
    id_valid      = 1'b0;
    id_reg_write  = 1'b0;
    id_mem_read   = 1'b0;
    id_mem_write  = 1'b0;
    id_branch     = 1'b0;
    id_alu_src    = 1'b0;
    id_mem_to_reg = 1'b0;
    id_alu_op     = ALU_ADD;
    id_illegal    = 1'b0;

    if (valid_q) begin
      rs1      = f_rs1;
      id_pc    = pc_q;
      id_valid = 1'b1;

      unique case (cls)
        CLS_R: begin
          rs2          = f_rs2;
          id_rd        = f_rd;
          id_reg_write = 1'b1;
          id_alu_op    = ALU_R;
        end
        CLS_I_ALU: begin
          id_rd        = f_rd;
          id_imm       = imm_i;
          id_reg_write = 1'b1;
          id_alu_src   = 1'b1;
          id_alu_op    = ALU_IMM;
        end
        CLS_LOAD: begin
          id_rd         = f_rd;
          id_imm        = imm_i;
          id_reg_write  = 1'b1;
          id_mem_read   = 1'b1;
          id_mem_to_reg = 1'b1;
          id_alu_src    = 1'b1;
          id_alu_op     = ALU_ADD;
        end
        CLS_STORE: begin
          rs2          = f_rs2;
          id_imm       = imm_s;
          id_mem_write = 1'b1;
          id_alu_src   = 1'b1;
          id_alu_op    = ALU_ADD;
        end
        CLS_BRANCH: begin
          rs2       = f_rs2;
          id_imm    = imm_sb;
          id_branch = 1'b1;
          id_alu_op = ALU_CMP;
        end
        default: begin
          id_illegal = 1'b1;
        end
      endcase

      // Bubble: downstream sees nothing to execute, but the register file
      // keeps reading the held operands for the replay next cycle.
      if (stall) begin
        id_valid      = 1'b0;
        id_rd         = '0;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_branch     = 1'b0;
        id_alu_src    = 1'b0;
        id_mem_to_reg = 1'b0;
        id_alu_op     = ALU_ADD;
        id_illegal    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a rule-level model of the IF/ID register and decoder.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  id_rd;
  logic [63:0] id_pc;
  logic [63:0] id_imm;
  logic        id_valid;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_alu_src;
  logic        id_mem_to_reg;
  logic [1:0]  id_alu_op;
  logic        id_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.XLEN(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .flush         (flush),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .stall         (stall),
    .rs1           (rs1),
    .rs2           (rs2),
    .id_rd         (id_rd),
    .id_pc         (id_pc),
    .id_imm        (id_imm),
    .id_valid      (id_valid),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_branch     (id_branch),
    .id_alu_src    (id_alu_src),
    .id_mem_to_reg (id_mem_to_reg),
    .id_alu_op     (id_alu_op),
    .id_illegal    (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg}
  logic [5:0] ctl;
  assign ctl = {id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src, id_mem_to_reg};

  typedef struct packed {
    logic        stall;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        valid;
    logic [5:0]  ctl;
    logic [1:0]  op;
    logic        ill;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [63:0] pc, input logic [31:0] ins);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = ins;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; if_valid = 1'b1; if_instr = 32'h002082B3; if_pc = 64'h40;
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    tick();
    n_checks++;
    if ({stall, rs1, rs2, id_rd, id_pc, id_imm, id_valid, ctl, id_alu_op, id_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b rs1=%0d rs2=%0d rd=%0d pc=%h imm=%h ctl=%b op=%b ill=%b stall=%b, required all zero",
               id_valid, rs1, rs2, id_rd, id_pc, id_imm, ctl, id_alu_op, id_illegal, stall);
    end
    reset = 1'b0;
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_rtype();
    fetch(64'h40, 32'h002082B3);
    n_checks++;
    if ({id_valid, rs1, rs2, id_rd} !== {1'b1, 5'd1, 5'd2, 5'd5}) begin
      n_fail++; $display("FAIL rtype_fields: got v=%b rs1=%0d rs2=%0d rd=%0d, required 1 1 2 5", id_valid, rs1, rs2, id_rd);
    end
    n_checks++;
    if (id_pc !== 64'h40) begin n_fail++; $display("FAIL rtype_pc: got %h required 40", id_pc); end
    n_checks++;
    if ({ctl, id_alu_op, id_imm} !== {6'b100000, 2'b10, 64'd0}) begin
      n_fail++; $display("FAIL rtype_ctl: got ctl=%b op=%b imm=%h, required 100000 10 0", ctl, id_alu_op, id_imm);
    end
  endtask

  task automatic test_load();
    fetch(64'h44, 32'h00823303);
    n_checks++;
    if ({rs1, rs2, id_rd, id_imm} !== {5'd4, 5'd0, 5'd6, 64'd8}) begin
      n_fail++; $display("FAIL load_fields: got rs1=%0d rs2=%0d rd=%0d imm=%h, required 4 0 6 8", rs1, rs2, id_rd, id_imm);
    end
    n_checks++;
    if ({ctl, id_alu_op} !== {6'b110011, 2'b00}) begin
      n_fail++; $display("FAIL load_ctl: got ctl=%b op=%b, required 110011 00", ctl, id_alu_op);
    end
  endtask

  task automatic test_load_use_stall();
    fetch(64'h48, 32'h001303B3);
    ex_mem_read = 1'b1; ex_rd = 5'd6;
    if_instr = 32'h0000007F; if_pc = 64'h99;
    #1;
    n_checks++;
    if ({stall, id_valid, ctl, id_alu_op} !== {1'b1, 1'b0, 6'd0, 2'd0}) begin
      n_fail++; $display("FAIL stall_bubble: got stall=%b v=%b ctl=%b op=%b, required 1 0 0 0", stall, id_valid, ctl, id_alu_op);
    end
    n_checks++;
    if ({rs1, rs2} !== {5'd6, 5'd1}) begin
      n_fail++; $display("FAIL stall_rf_addr: got rs1=%0d rs2=%0d, required 6 1", rs1, rs2);
    end
    tick();
    ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if ({stall, id_valid, id_rd, id_pc} !== {1'b0, 1'b1, 5'd7, 64'h48}) begin
      n_fail++; $display("FAIL stall_replay: got stall=%b v=%b rd=%0d pc=%h, required 0 1 7 48", stall, id_valid, id_rd, id_pc);
    end
  endtask

  task automatic test_store();
    fetch(64'h4C, 32'hFE512E23);
    n_checks++;
    if (id_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL store_imm: got %h required fffffffffffffffc", id_imm); end
    n_checks++;
    if ({ctl, id_rd, rs1, rs2} !== {6'b001010, 5'd0, 5'd2, 5'd5}) begin
      n_fail++; $display("FAIL store_ctl: got ctl=%b rd=%0d rs1=%0d rs2=%0d, required 001010 0 2 5", ctl, id_rd, rs1, rs2);
    end
  endtask

  task automatic test_branch();
    fetch(64'h50, 32'hFE208CE3);
    n_checks++;
    if (id_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL branch_imm: got %h required fffffffffffffff8", id_imm); end
    n_checks++;
    if ({ctl, id_alu_op, id_rd} !== {6'b000100, 2'b01, 5'd0}) begin
      n_fail++; $display("FAIL branch_ctl: got ctl=%b op=%b rd=%0d, required 000100 01 0", ctl, id_alu_op, id_rd);
    end
  endtask

  task automatic test_flush_beats_hazard();
    fetch(64'h54, 32'h001303B3);
    ex_mem_read = 1'b1; ex_rd = 5'd6; flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b required 0", stall); end
    tick();
    flush = 1'b0; ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got id_valid=%b required 0", id_valid); end
  endtask

  task automatic test_illegal();
    fetch(64'h58, 32'h0000007F);
    n_checks++;
    if ({id_valid, id_illegal, ctl, id_alu_op} !== {1'b1, 1'b1, 6'd0, 2'd0}) begin
      n_fail++; $display("FAIL illegal: got v=%b ill=%b ctl=%b op=%b, required 1 1 0 0", id_valid, id_illegal, ctl, id_alu_op);
    end
  endtask

  task automatic test_x0_no_hazard();
    fetch(64'h5C, 32'h00500193);
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    n_checks++;
    if ({stall, id_valid, rs1} !== {1'b0, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL x0_hazard: got stall=%b v=%b rs1=%0d, required 0 1 0", stall, id_valid, rs1);
    end
    ex_mem_read = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    fetch(64'h60, 32'h001303B3);
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pre: got stall=%b required 1", stall); end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({stall, id_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_stall_post: got stall=%b v=%b, required 0 0", stall, id_valid);
    end
    reset = 1'b0; ex_mem_read = 1'b0; if_valid = 1'b0;
    tick();
  endtask

  // Reference decode written directly from the instruction-format rules.
  function automatic obs_t model(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                                 input logic emr, input logic [4:0] erd, input logic fl);
    obs_t e;
    logic is_r, is_i, is_ld, is_st, is_br, u1, u2, hz;
    e     = '0;
    is_r  = (ins[6:0] == 7'b0110011);
    is_i  = (ins[6:0] == 7'b0010011);
    is_ld = (ins[6:0] == 7'b0000011);
    is_st = (ins[6:0] == 7'b0100011);
    is_br = (ins[6:0] == 7'b1100011);
    u1    = is_r | is_i | is_ld | is_st | is_br;
    u2    = is_r | is_st | is_br;
    if (!v) return e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.rs1   = ins[19:15];
    if (u2) e.rs2 = ins[24:20];
    if (is_r | is_i | is_ld) e.rd = ins[11:7];
    e.ctl = {is_r | is_i | is_ld, is_ld, is_st, is_br, is_i | is_ld | is_st, is_ld};
    e.op  = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
    e.ill = !u1;
    if (is_i | is_ld)  e.imm = longint'($signed(ins[31:20]));
    else if (is_st)    e.imm = longint'($signed({ins[31:25], ins[11:7]}));
    else if (is_br)    e.imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    hz = emr && (erd != 5'd0) && ((u1 && ins[19:15] == erd) || (u2 && ins[24:20] == erd));
    e.stall = hz && !fl;
    if (e.stall) begin
      e.valid = 1'b0; e.rd = '0; e.ctl = '0; e.op = '0; e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] ops [6];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
    w = $urandom();
    w[6:0]   = ops[$urandom_range(0, 5)];
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_random();
    logic        m_valid;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    obs_t exp_o, got_o;
    reset = 1'b1; flush = 1'b0; ex_mem_read = 1'b0;
    tick();
    m_valid = 1'b0; m_pc = '0; m_instr = '0;
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      if_valid    = ($urandom_range(0, 3) != 0);
      if_pc       = {$urandom(), $urandom()};
      if_instr    = rand_instr();
      flush       = ($urandom_range(0, 9) == 0);
      ex_mem_read = $urandom_range(0, 1);
      ex_rd       = 5'($urandom_range(0, 3));
      #1;
      exp_o = model(m_valid, m_pc, m_instr, ex_mem_read, ex_rd, flush);
      got_o = '{stall: stall, rs1: rs1, rs2: rs2, rd: id_rd, pc: id_pc, imm: id_imm,
                valid: id_valid, ctl: ctl, op: id_alu_op, ill: id_illegal};
      if (exp_o.stall) begin
        got_o.pc = '0; got_o.imm = '0; exp_o.pc = '0; exp_o.imm = '0;
      end
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h (instr=%h)", i, got_o, exp_o, m_instr);
      end
      @(posedge clk);
      if (reset) begin
        m_valid = 1'b0; m_pc = '0; m_instr = '0;
      end else if (flush) begin
        m_valid = 1'b0;
      end else if (!exp_o.stall) begin
        m_valid = if_valid; m_pc = if_pc; m_instr = if_instr;
      end
      #1;
    end
    reset = 1'b0; flush = 1'b0; ex_mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_load_use_stall();
    test_store();
    test_branch();
    test_flush_beats_hazard();
    test_illegal();
    test_x0_no_hazard();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID pipeline register plus instruction decoder for the 64-bit RISC-V core.
- Sits directly upstream of the register file:
  - drives the register file's RS1/RS2 read addresses from the latched instruction;
  - forwards RD and control signals, which travel down the pipe to writeback (RegWrite/RD).
- Also produces the sign-extended immediate and detects load-use hazards, stalling fetch and inserting bubbles.

Parameters:
- XLEN, 64, datapath/PC width; immediate sign-extended to XLEN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_pc  in  XLEN  PC of fetched instruction.
- if_instr  in  32  fetched instruction word.
- flush  in  1  branch taken/redirect; kill instruction in ID.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination register of instruction in EX.
- stall  out  1  hold PC and fetch; combinational.
- rs1  out  5  register-file read address 1.
- rs2  out  5  register-file read address 2.
- id_rd  out  5  destination register.
- id_pc  out  XLEN  latched PC.
- id_imm  out  XLEN  sign-extended immediate.
- id_valid  out  1  ID holds a live, non-bubble instruction.
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src, id_mem_to_reg  out  1 each  control.
- id_alu_op  out  2  00 load/store add, 01 branch compare, 10 R-type, 11 I-type ALU.
- id_illegal  out  1  valid instruction with unsupported opcode.

Behaviour:
- State: valid_q, pc_q, instr_q (IF/ID register).
- Reset values: valid_q=0, pc_q=0, instr_q=0. With valid_q=0 every output is 0, including rs1/rs2/id_rd/id_imm.
- Register update priority, per clock:
  - reset.
  - Else flush: valid_q<=0. pc_q/instr_q are don't-care.
  - Else stall: hold all state.
  - Else load valid_q<=if_valid, pc_q<=if_pc, instr_q<=if_instr.
- Decode is combinational from instr_q, gated by valid_q. Latency: 1 cycle from fetch to ID outputs.
- Fields: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0].
- Supported opcodes:
  - 0110011 R: reg_write, alu_op=10.
  - 0010011 I-ALU: reg_write, alu_src, alu_op=11, I-imm.
  - 0000011 load: reg_write, mem_read, mem_to_reg, alu_src, alu_op=00, I-imm.
  - 0100011 store: mem_write, alu_src, alu_op=00, S-imm, id_rd=0.
  - 1100011 branch: branch, alu_op=01, SB-imm (bit0=0), id_rd=0.
  - Any other opcode with valid_q=1: id_illegal=1, all controls 0, id_valid stays 1.
- Immediates are sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - SB: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - R-type: imm=0.
- rs2 is driven only for R/store/branch; otherwise 0.
- uses_rs1 = R/I-ALU/load/store/branch; uses_rs2 = R/store/branch.
- hazard = valid_q & ex_mem_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- stall = hazard & ~flush.
- While stall=1: ID outputs become a bubble (id_valid=0, all controls 0). rs1/rs2 still drive the register file. The instruction is held and re-decoded next cycle. Stall lasts exactly 1 cycle, because EX then holds the bubble.
- Flush and hazard in the same cycle: flush wins, stall=0, next cycle valid_q=0.
- reset asserted mid-stall: valid_q=0 next cycle, stall drops.
- x0 destination never triggers a hazard.

Test Plan:
- Reset then if_valid=1, if_instr=0x002082B3 (add x5,x1,x2), if_pc=0x40 -> next cycle:
  - id_valid=1, rs1=1, rs2=2, id_rd=5, id_pc=0x40;
  - id_reg_write=1, id_alu_op=10, id_imm=0.
- if_instr=0x00823303 (ld x6,8(x4)) -> rs1=4, rs2=0, id_rd=6, id_imm=8, mem_read=mem_to_reg=alu_src=reg_write=1, alu_op=00.
- ID holds 0x001303B3 (add x7,x6,x1), ex_mem_read=1, ex_rd=6:
  - stall=1, id_valid=0, all controls 0;
  - next edge: instr_q unchanged;
  - with ex_mem_read=0: stall=0, id_valid=1, id_rd=7.
- if_instr=0xFE512E23 (sw x5,-4(x2)) -> id_imm=0xFFFFFFFFFFFFFFFC, mem_write=1, id_rd=0, rs2=5.
- if_instr=0xFE208CE3 (beq x1,x2,-8) -> id_imm=0xFFFFFFFFFFFFFFF8, branch=1, alu_op=01.
- Hazard condition plus flush=1 in the same cycle -> stall=0. Next cycle id_valid=0.
- Opcode 0x7F valid -> id_illegal=1, all controls 0.
- ex_rd=0 with ex_mem_read=1 and rs1=0 -> no stall.
